// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings, state type and default widths for the CPU sequencer
package cpu_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_OPC_W  = 3;
  // Wide enough to hold ALU_LAT-1 for any latency from 1 to 8.
  localparam int LAT_CNT_W  = 3;

  localparam logic [1:0] PH_LOAD = 2'b00;
  localparam logic [1:0] PH_EXEC = 2'b01;
  localparam logic [1:0] PH_OUT  = 2'b10;
  localparam logic [1:0] PH_IDLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_OUT    = 3'd5
  } state_e;

  // Map a sequencer state onto the two-bit phase seen by the datapath.
  function automatic logic [1:0] phase_of(state_e s);
    logic [1:0] ph;
    ph = PH_IDLE;
    case (s)
      ST_LOAD_A, ST_LOAD_B: ph = PH_LOAD;
      ST_EXEC, ST_WAIT:     ph = PH_EXEC;
      ST_OUT:               ph = PH_OUT;
      default:              ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/seq_lat_counter.sv
// rtl/seq_lat_counter.sv - loadable down-counter with zero flag for the ALU latency wait
module seq_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load takes priority; decrement stops at zero so the flag stays asserted.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - request handshake, LOAD/EXEC/OUT sequencing and result capture
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OPC_W-1:0]  opcode_in,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              ack,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic [1:0]        phase,
  output logic              reg_wr_en,
  output logic              reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              inst_wr_en,
  output logic [DATA_W-1:0] inst_wdata,
  output logic              alu_en,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [CNT_W-1:0]  ops_done
);

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               rv_q, rv_d;
  logic [CNT_W-1:0]   ops_q, ops_d;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;

  seq_lat_counter #(
    .W (LAT_CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_CNT_W'(ALU_LAT - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state logic; operands are only captured in IDLE so later input changes are ignored.
  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    rv_d     = rv_q;
    ops_d    = ops_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opc_d   = opcode_in;
          a_d     = op_a;
          b_d     = op_b;
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_EXEC;
      ST_EXEC: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          result_d = alu_result;
          rv_d     = 1'b1;
          state_d  = ST_OUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_OUT: begin
        if (ack) begin
          rv_d    = 1'b0;
          ops_d   = ops_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand latches, result and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      ops_q    <= ops_d;
    end
  end

  // Moore output decode; write data is forced to zero whenever its enable is low.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    phase      = phase_of(state_q);
    reg_wr_en  = 1'b0;
    reg_addr   = 1'b0;
    reg_wdata  = '0;
    inst_wr_en = 1'b0;
    inst_wdata = '0;
    alu_en     = 1'b0;
    case (state_q)
      ST_LOAD_A: begin
        reg_wr_en  = 1'b1;
        reg_wdata  = a_q;
        inst_wr_en = 1'b1;
        inst_wdata = DATA_W'(opc_q);
      end
      ST_LOAD_B: begin
        reg_wr_en = 1'b1;
        reg_addr  = 1'b1;
        reg_wdata = b_q;
      end
      ST_EXEC: alu_en = 1'b1;
      default: ;
    endcase
  end

  assign alu_opcode   = opc_q;
  assign alu_in_1     = a_q;
  assign alu_in_2     = b_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign ops_done     = ops_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer at ALU latencies 1 and 3
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start [2];
  logic [2:0] opc [2];
  logic [3:0] op_a [2];
  logic [3:0] op_b [2];
  logic       ack [2];
  logic [3:0] alu_result [2];

  logic       busy [2];
  logic [1:0] phase [2];
  logic       reg_wr_en [2];
  logic       reg_addr [2];
  logic [3:0] reg_wdata [2];
  logic       inst_wr_en [2];
  logic [3:0] inst_wdata [2];
  logic       alu_en [2];
  logic [2:0] alu_opcode [2];
  logic [3:0] alu_in_1 [2];
  logic [3:0] alu_in_2 [2];
  logic [3:0] result [2];
  logic       result_valid [2];
  logic [7:0] ops_done [2];

  int         checks = 0;
  int         errors = 0;
  logic [3:0] sb0 [$];
  logic [3:0] sb1 [$];
  logic       rv_prev [2];
  int         ops_exp [2];

  always #5 clk = ~clk;

  // Instance 0 uses ALU_LAT=1, instance 1 uses ALU_LAT=3; each has a combinational adder ALU.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_sequencer #(
      .ALU_LAT ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start[g]),
      .opcode_in    (opc[g]),
      .op_a         (op_a[g]),
      .op_b         (op_b[g]),
      .ack          (ack[g]),
      .alu_result   (alu_result[g]),
      .busy         (busy[g]),
      .phase        (phase[g]),
      .reg_wr_en    (reg_wr_en[g]),
      .reg_addr     (reg_addr[g]),
      .reg_wdata    (reg_wdata[g]),
      .inst_wr_en   (inst_wr_en[g]),
      .inst_wdata   (inst_wdata[g]),
      .alu_en       (alu_en[g]),
      .alu_opcode   (alu_opcode[g]),
      .alu_in_1     (alu_in_1[g]),
      .alu_in_2     (alu_in_2[g]),
      .result       (result[g]),
      .result_valid (result_valid[g]),
      .ops_done     (ops_done[g])
    );
    assign alu_result[g] = alu_in_1[g] + alu_in_2[g];
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(int k, logic [3:0] v);
    if (k == 0) sb0.push_back(v);
    else sb1.push_back(v);
  endtask

  // Scoreboard: each rising result_valid consumes one expected result.
  always @(negedge clk) begin
    if (result_valid[0] === 1'b1 && rv_prev[0] !== 1'b1) begin
      if (sb0.size() == 0) check("sb0_unexpected", {28'd0, result[0]}, 32'hFFFF_FFFF);
      else check("sb0_result", {28'd0, result[0]}, {28'd0, sb0.pop_front()});
    end
    if (result_valid[1] === 1'b1 && rv_prev[1] !== 1'b1) begin
      if (sb1.size() == 0) check("sb1_unexpected", {28'd0, result[1]}, 32'hFFFF_FFFF);
      else check("sb1_result", {28'd0, result[1]}, {28'd0, sb1.pop_front()});
    end
    rv_prev[0] = result_valid[0];
    rv_prev[1] = result_valid[1];
  end

  // Drive one request and follow it cycle by cycle until OUT; optionally disturb inputs meanwhile.
  task automatic run_op(int k, logic [2:0] o, logic [3:0] x, logic [3:0] y, bit disturb);
    int lat;
    int en_seen;
    lat = (k == 0) ? 1 : 3;
    en_seen = 0;
    opc[k] = o; op_a[k] = x; op_b[k] = y; start[k] = 1'b1;
    push_exp(k, x + y);
    step();
    start[k] = 1'b0;
    check("loada_phase", {busy[k], phase[k]}, 3'b100);
    check("loada_reg", {reg_wr_en[k], reg_addr[k], reg_wdata[k]}, {2'b10, x});
    check("loada_inst", {inst_wr_en[k], inst_wdata[k]}, {2'b10, o});
    en_seen += int'(alu_en[k]);
    if (disturb) begin
      op_a[k] = 4'hA; start[k] = 1'b1; ack[k] = 1'b1;
    end
    step();
    check("loadb_reg", {phase[k], reg_wr_en[k], reg_addr[k], reg_wdata[k]}, {4'b0011, y});
    check("loadb_inst", {inst_wr_en[k], inst_wdata[k]}, 5'd0);
    en_seen += int'(alu_en[k]);
    step();
    check("exec_state", {phase[k], alu_en[k], reg_wr_en[k]}, 4'b0110);
    en_seen += int'(alu_en[k]);
    for (int i = 0; i < lat; i++) begin
      step();
      check("wait_state", {phase[k], alu_en[k], result_valid[k]}, 4'b0100);
      check("wait_alu_in_1", alu_in_1[k], x);
      en_seen += int'(alu_en[k]);
    end
    step();
    check("out_state", {phase[k], busy[k], result_valid[k]}, 4'b1011);
    check("out_latches", {alu_opcode[k], alu_in_1[k], alu_in_2[k]}, {o, x, y});
    en_seen += int'(alu_en[k]);
    check("alu_en_pulses", en_seen, 1);
    if (disturb) begin
      start[k] = 1'b0; ack[k] = 1'b0;
    end
  endtask

  task automatic do_ack(int k, logic [3:0] exp_res);
    ack[k] = 1'b1;
    step();
    ack[k] = 1'b0;
    ops_exp[k] = (ops_exp[k] + 1) % 256;
    check("ack_idle", {phase[k], busy[k], result_valid[k]}, 4'b1100);
    check("ops_done", ops_done[k], ops_exp[k]);
    check("result_hold", result[k], exp_res);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; opc[k] = '0; op_a[k] = '0; op_b[k] = '0; ack[k] = 1'b0;
      rv_prev[k] = 1'b0; ops_exp[k] = 0;
    end

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_phase", {busy[k], phase[k]}, 3'b011);
      check("rst_ctl", {reg_wr_en[k], reg_addr[k], reg_wdata[k], inst_wr_en[k], inst_wdata[k], alu_en[k]}, 12'd0);
      check("rst_data", {alu_opcode[k], alu_in_1[k], alu_in_2[k], result[k], result_valid[k], ops_done[k]}, 24'd0);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
    check("idle_no_start", {phase[0], busy[0], phase[1], busy[1]}, 6'b110110);

    // Basic operation at latency 1, OUT holds without ack.
    run_op(0, 3'b010, 4'h5, 4'h3, 1'b0);
    step();
    check("out_hold", {phase[0], result_valid[0], result[0]}, {3'b101, 4'h8});
    do_ack(0, 4'h8);

    // Latency 3 with wrapping sum.
    run_op(1, 3'b000, 4'hF, 4'h2, 1'b0);
    do_ack(1, 4'h1);

    // Start/op_a/ack activity while busy is ignored.
    run_op(0, 3'b001, 4'h5, 4'h4, 1'b1);
    do_ack(0, 4'h9);
    check("idle_latches", {alu_opcode[0], alu_in_1[0], alu_in_2[0]}, {3'b001, 4'h5, 4'h4});

    // Reset during WAIT on the latency-3 instance.
    opc[1] = 3'b011; op_a[1] = 4'h6; op_b[1] = 4'h7; start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    repeat (3) step();
    check("pre_rst_wait", {phase[1], busy[1]}, 3'b011);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_state", {phase[1], busy[1], result_valid[1]}, 4'b1100);
    check("mid_rst_data", {result[1], ops_done[1], alu_in_1[1]}, 16'd0);
    ops_exp[0] = 0; ops_exp[1] = 0;
    #2 rst = 1'b0;
    run_op(1, 3'b011, 4'h6, 4'h7, 1'b0);
    do_ack(1, 4'hD);

    // start and ack together in OUT: only the return to IDLE happens.
    run_op(0, 3'b100, 4'h2, 4'h2, 1'b0);
    start[0] = 1'b1; ack[0] = 1'b1;
    step();
    start[0] = 1'b0; ack[0] = 1'b0;
    ops_exp[0] = (ops_exp[0] + 1) % 256;
    check("start_ack_idle", {phase[0], busy[0]}, 3'b110);
    check("start_ack_ops", ops_done[0], ops_exp[0]);
    step();
    check("start_ack_no_capture", {phase[0], busy[0], alu_in_1[0]}, {3'b110, 4'h2});

    // 256 back-to-back operations with ack held high: ops_done wraps to zero.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    ops_exp[0] = 0; ops_exp[1] = 0;
    ack[0] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      int wd;
      op_a[0] = 4'($urandom); op_b[0] = 4'($urandom); opc[0] = 3'($urandom);
      start[0] = 1'b1;
      push_exp(0, op_a[0] + op_b[0]);
      step();
      start[0] = 1'b0;
      wd = 0;
      while (phase[0] != 2'b11 && wd < 20) begin
        step();
        wd++;
      end
      check("b2b_cycles", wd, 5);
      ops_exp[0] = (ops_exp[0] + 1) % 256;
      if (i == 254) check("ops_255", ops_done[0], 255);
    end
    ack[0] = 1'b0;
    check("ops_wrap", ops_done[0], ops_exp[0]);
    check("ops_wrap_zero", ops_done[0], 0);

    step();
    check("sb0_drain", sb0.size(), 0);
    check("sb1_drain", sb1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
